// File: rtl/mult_unit_seq.sv
// Multi-cycle signed shift-add multiplier holding the HI/LO registers.
// Stalls the pipeline while a product is in flight and serves LO for mflo.
module mult_unit_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_operation,
    input  logic             mflo_flag,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mflo_data
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   abs_a_c;
    logic [WIDTH-1:0]   abs_b_c;
    logic [WIDTH:0]     sum_c;
    logic [ACC_W-1:0]   product_c;
    logic               last_iter_c;

    // Magnitudes; the most negative value maps onto itself as an unsigned magnitude.
    assign abs_a_c     = srcA[WIDTH-1] ? WIDTH'(-srcA) : srcA;
    assign abs_b_c     = srcB[WIDTH-1] ? WIDTH'(-srcB) : srcB;
    assign sum_c       = {1'b0, acc[ACC_W-1:WIDTH]} + (mag_b[cnt] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    assign product_c   = neg ? ACC_W'(-acc) : acc;
    assign last_iter_c = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mult_operation) state_nxt = RUN;
            RUN:     if (last_iter_c)    state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = 1'b0;
        stall     = 1'b0;
        mflo_data = lo;
        busy      = (state != IDLE);
        stall     = busy & (mult_operation | mflo_flag);
    end

    // Datapath: operand capture, shift-add iterations, sign fix-up into HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mult_operation) begin
                        mag_a <= abs_a_c;
                        mag_b <= abs_b_c;
                        neg   <= srcA[WIDTH-1] ^ srcB[WIDTH-1];
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= {sum_c, acc[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    hi   <= product_c[ACC_W-1:WIDTH];
                    lo   <= product_c[WIDTH-1:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
